// File: rtl/arbiter_pkg.sv
// Shared types and constants for the memory arbiter and its helpers.
package arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int STRB_W = 4;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin selector: picks the first requesting index
// strictly after 'last', wrapping around, so 'last' itself has lowest priority.
module round_robin_picker #(
   parameter int N_REQ = 2,
   parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] request,
   input  logic [IW-1:0]    last,
   output logic [IW-1:0]    grant,
   output logic             any
);

   logic [IW-1:0] idx;

   // Scan from the farthest offset back to the nearest so the closest
   // requester after 'last' overwrites any earlier candidate.
   always_comb begin
      grant = '0;
      any   = 1'b0;
      idx   = '0;
      for (int off = N_REQ; off >= 1; off--) begin
         idx = IW'((int'(last) + off) % N_REQ);
         if (request[idx]) begin
            grant = idx;
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between N_REQ requesters,
// one transaction outstanding at a time, with a response timeout guard.
module memory_arbiter
   import arbiter_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_request,
   input  logic [N_REQ-1:0]      req_command,
   input  logic [N_REQ*32-1:0]   req_address,
   input  logic [N_REQ*32-1:0]   req_write_data,
   input  logic [N_REQ*4-1:0]    req_write_strobe,
   output logic [N_REQ-1:0]      req_ready,
   output logic [N_REQ-1:0]      req_valid,
   output logic                  req_error,
   output logic [31:0]           req_read_data,
   input  logic                  mem_ready,
   output logic                  mem_enable,
   output logic                  mem_command,
   output logic [31:0]           mem_address,
   output logic [31:0]           mem_write_data,
   output logic [3:0]            mem_write_strobe,
   input  logic                  mem_valid,
   input  logic [31:0]           mem_read_data,
   output logic                  late_response
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_t     state_reg;
   logic [IW-1:0]  owner_reg;
   logic [IW-1:0]  last_grant_reg;
   logic [CW-1:0]  counter_reg;
   logic           late_reg;

   logic [IW-1:0]  grant;
   logic           any;
   logic           fire;
   logic           busy;
   logic           timeout_hit;
   logic           respond;

   logic [ADDR_W-1:0] addr_arr  [N_REQ];
   logic [DATA_W-1:0] wdata_arr [N_REQ];
   logic [STRB_W-1:0] strb_arr  [N_REQ];

   // Unpack the flat per-requester buses for indexed selection.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_address[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_write_data[gi*DATA_W +: DATA_W];
      assign strb_arr[gi]  = req_write_strobe[gi*STRB_W +: STRB_W];
   end

   round_robin_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
      .request (req_request),
      .last    (last_grant_reg),
      .grant   (grant),
      .any     (any)
   );

   // Outputs are forced quiet while reset is held so nothing is issued or answered.
   assign fire        = !reset && (state_reg == ARB_IDLE) && any && mem_ready;
   assign busy        = !reset && (state_reg == ARB_BUSY);
   assign timeout_hit = (counter_reg == CW'(TIMEOUT_CYCLES - 1));
   assign respond     = busy && (mem_valid || timeout_hit);

   // Command path: the granted requester drives the memory port directly in the accept cycle.
   always_comb begin
      req_ready        = '0;
      mem_enable       = 1'b0;
      mem_command      = MEM_READ;
      mem_address      = '0;
      mem_write_data   = '0;
      mem_write_strobe = '0;
      if (fire) begin
         req_ready[grant] = 1'b1;
         mem_enable       = 1'b1;
         mem_command      = req_command[grant];
         mem_address      = addr_arr[grant];
         mem_write_data   = wdata_arr[grant];
         mem_write_strobe = strb_arr[grant];
      end
   end

   // Response path: a real response always beats a simultaneous timeout.
   always_comb begin
      req_valid     = '0;
      req_error     = 1'b0;
      req_read_data = '0;
      if (respond) begin
         req_valid[owner_reg] = 1'b1;
         req_error            = !mem_valid;
         req_read_data        = mem_valid ? mem_read_data : '0;
      end
   end

   assign late_response = late_reg;

   // Arbitration FSM with ownership, round-robin pointer and timeout counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ARB_IDLE;
         owner_reg      <= '0;
         last_grant_reg <= IW'(N_REQ - 1);
         counter_reg    <= '0;
         late_reg       <= 1'b0;
      end else begin
         case (state_reg)
            ARB_IDLE: begin
               if (mem_valid) begin
                  late_reg <= 1'b1;
               end
               if (fire) begin
                  owner_reg      <= grant;
                  last_grant_reg <= grant;
                  counter_reg    <= '0;
                  state_reg      <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (respond) begin
                  counter_reg <= '0;
                  state_reg   <= ARB_IDLE;
               end else begin
                  counter_reg <= counter_reg + 1'b1;
               end
            end
            default: state_reg <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios followed by
// random traffic, every output compared each cycle against a transaction model.
module tb_memory_arbiter;

   localparam int N = 2;
   localparam int T = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_request = '0;
   logic [N-1:0]    req_command = '0;
   logic [N*32-1:0] req_address = '0;
   logic [N*32-1:0] req_write_data = '0;
   logic [N*4-1:0]  req_write_strobe = '0;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_valid;
   logic            req_error;
   logic [31:0]     req_read_data;
   logic            mem_ready = 1'b0;
   logic            mem_enable;
   logic            mem_command;
   logic [31:0]     mem_address;
   logic [31:0]     mem_write_data;
   logic [3:0]      mem_write_strobe;
   logic            mem_valid = 1'b0;
   logic [31:0]     mem_read_data = '0;
   logic            late_response;

   memory_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_request      (req_request),
      .req_command      (req_command),
      .req_address      (req_address),
      .req_write_data   (req_write_data),
      .req_write_strobe (req_write_strobe),
      .req_ready        (req_ready),
      .req_valid        (req_valid),
      .req_error        (req_error),
      .req_read_data    (req_read_data),
      .mem_ready        (mem_ready),
      .mem_enable       (mem_enable),
      .mem_command      (mem_command),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_write_strobe (mem_write_strobe),
      .mem_valid        (mem_valid),
      .mem_read_data    (mem_read_data),
      .late_response    (late_response)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   // Transaction-level model: is a transfer outstanding, whose, and when it must be aborted.
   bit m_busy     = 1'b0;
   int m_owner    = 0;
   int m_last     = N - 1;
   int m_deadline = 0;
   bit m_late     = 1'b0;
   bit m_is_write = 1'b0;

   // Expected outputs for the current cycle.
   logic [N-1:0] e_ready, e_valid;
   logic         e_error, e_en, e_cmd;
   logic [31:0]  e_rdata, e_addr, e_wdata;
   logic [3:0]   e_strb;
   int           e_grant;
   bit           e_fire, e_done;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // Next owner: first requester after the most recent grant, wrapping.
   function automatic int pick();
      for (int off = 1; off <= N; off++) begin
         if (req_request[(m_last + off) % N]) return (m_last + off) % N;
      end
      return -1;
   endfunction

   task automatic expect_outputs();
      e_ready = '0; e_valid = '0; e_error = 1'b0; e_rdata = '0;
      e_en = 1'b0; e_cmd = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0;
      e_grant = -1; e_fire = 1'b0; e_done = 1'b0;
      if (!reset) begin
         if (!m_busy) begin
            e_grant = pick();
            if (e_grant >= 0 && mem_ready) begin
               e_fire           = 1'b1;
               e_ready[e_grant] = 1'b1;
               e_en             = 1'b1;
               e_cmd            = req_command[e_grant];
               e_addr           = req_address[e_grant*32 +: 32];
               e_wdata          = req_write_data[e_grant*32 +: 32];
               e_strb           = req_write_strobe[e_grant*4 +: 4];
            end
         end else begin
            e_done = mem_valid || (cyc == m_deadline);
            if (e_done) begin
               e_valid[m_owner] = 1'b1;
               e_error          = !mem_valid;
               e_rdata          = mem_valid ? mem_read_data : 32'h0;
            end
         end
      end
   endtask

   task automatic update_model();
      if (reset) begin
         m_busy = 1'b0;
         m_last = N - 1;
         m_late = 1'b0;
      end else if (!m_busy) begin
         if (mem_valid) m_late = 1'b1;
         if (e_fire) begin
            m_busy     = 1'b1;
            m_owner    = e_grant;
            m_last     = e_grant;
            m_is_write = e_cmd;
            m_deadline = cyc + T;
         end
      end else if (e_done) begin
         m_busy = 1'b0;
         $display("[TB] cycle %0d txn owner=%0d %s err=%0d data=%h", cyc, m_owner,
                  m_is_write ? "wr" : "rd", e_error, e_rdata);
      end
   endtask

   // One clock: compare everything mid-cycle, then advance the model at the edge.
   task automatic tick();
      @(negedge clk);
      expect_outputs();
      check("req_ready",        32'(req_ready),        32'(e_ready));
      check("req_valid",        32'(req_valid),        32'(e_valid));
      check("req_error",        32'(req_error),        32'(e_error));
      check("req_read_data",    req_read_data,         e_rdata);
      check("mem_enable",       32'(mem_enable),       32'(e_en));
      check("mem_command",      32'(mem_command),      32'(e_cmd));
      check("mem_address",      mem_address,           e_addr);
      check("mem_write_data",   mem_write_data,        e_wdata);
      check("mem_write_strobe", 32'(mem_write_strobe), 32'(e_strb));
      check("late_response",    32'(late_response),    32'(m_late));
      @(posedge clk);
      update_model();
      cyc++;
      #1;
   endtask

   task automatic set_req(input int i, input logic cmd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
      req_command[i]              = cmd;
      req_address[i*32 +: 32]     = addr;
      req_write_data[i*32 +: 32]  = data;
      req_write_strobe[i*4 +: 4]  = strb;
   endtask

   task automatic quiet();
      req_request = '0;
      mem_valid   = 1'b0;
      mem_read_data = '0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset state
      tick();
      reset = 1'b0;

      // 1: single read with response on the second busy cycle
      mem_ready = 1'b1;
      set_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
      req_request = 2'b01;
      tick();
      quiet();
      tick();
      mem_valid = 1'b1; mem_read_data = 32'hDEADBEEF;
      tick();
      quiet();
      tick();

      // 2: both requesting continuously, memory answers one cycle after issue
      set_req(1, 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF);
      for (int k = 0; k < 8; k++) begin
         req_request = 2'b11;
         mem_valid = m_busy; mem_read_data = 32'h1000 + k;
         tick();
      end
      quiet();
      tick();

      // 3: requester 1 write held off by mem_ready low for three cycles
      set_req(1, 1'b1, 32'h200, 32'h12345678, 4'b0011);
      req_request = 2'b10;
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      mem_ready = 1'b1;
      tick();
      quiet();
      mem_valid = 1'b1; mem_read_data = 32'h0;
      tick();
      quiet();

      // 4: timeout on the fourth busy cycle, then a stray response
      req_request = 2'b01;
      tick();
      quiet();
      for (int k = 0; k < T; k++) tick();
      mem_valid = 1'b1; mem_read_data = 32'hBAD0BAD0;
      tick();
      quiet();
      tick();

      // 5: reset in the middle of a transaction, then both request
      reset = 1'b1; tick(); reset = 1'b0;
      req_request = 2'b01;
      tick();
      quiet();
      tick();
      reset = 1'b1; tick(); reset = 1'b0;
      req_request = 2'b11;
      tick();
      quiet();
      mem_valid = 1'b1; mem_read_data = 32'h55AA55AA;
      tick();
      quiet();

      // 6: response arriving in the abort cycle wins over the timeout
      req_request = 2'b10;
      tick();
      quiet();
      for (int k = 0; k < T - 1; k++) tick();
      mem_valid = 1'b1; mem_read_data = 32'hC0FFEE00;
      tick();
      quiet();
      tick();

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         reset            = ($urandom_range(0, 60) == 0);
         req_request      = N'($urandom);
         req_command      = N'($urandom);
         req_address      = {$urandom, $urandom};
         req_write_data   = {$urandom, $urandom};
         req_write_strobe = 8'($urandom);
         mem_ready        = ($urandom_range(0, 3) != 0);
         mem_valid        = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
         mem_read_data    = $urandom;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
